// File: rtl/spm_banked.sv
// spm_banked: word-interleaved, multi-bank scratchpad shared by a CPU port and a DMA port.
// Accesses to different banks proceed in parallel. On a same-bank conflict the CPU wins,
// unless the DMA has already been held off STARVE_LIMIT times in a row.
module spm_banked #(
    parameter int SIZE_IN_BYTES = 8192,
    parameter int NUM_BANKS     = 4,
    parameter int STARVE_LIMIT  = 4,
    localparam int AW = $clog2(SIZE_IN_BYTES / 4),
    localparam int BW = $clog2(NUM_BANKS)
) (
    input  logic          clock,
    input  logic          reset,
    // CPU port
    input  logic          spmCs,
    input  logic          spmWe,
    input  logic [AW-1:0] spmAddress,
    input  logic [3:0]    spmByteEnables,
    input  logic [31:0]   dataToSpm,
    output logic [31:0]   dataFromSpm,
    output logic          spmStall,
    // DMA port
    input  logic          dmaReq,
    input  logic          dmaWe,
    input  logic [AW-1:0] dmaAddress,
    input  logic [3:0]    dmaByteEnables,
    input  logic [31:0]   dmaDataIn,
    output logic          dmaAck,
    output logic [31:0]   dmaDataOut,
    output logic          dmaReadValid
);

    localparam int BSW  = (BW > 0) ? BW : 1;
    localparam int RW   = AW - BW;
    localparam int ROWS = 1 << RW;
    localparam int SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    if (NUM_BANKS != 1 && NUM_BANKS != 2 && NUM_BANKS != 4 && NUM_BANKS != 8) begin : gBadBanks
        $error("spm_banked: NUM_BANKS must be 1, 2, 4 or 8");
    end
    if (SIZE_IN_BYTES < 16 * NUM_BANKS || (SIZE_IN_BYTES & (SIZE_IN_BYTES - 1)) != 0) begin : gBadSize
        $error("spm_banked: SIZE_IN_BYTES must be a power of two and at least 16*NUM_BANKS");
    end
    if (STARVE_LIMIT < 0) begin : gBadStarve
        $error("spm_banked: STARVE_LIMIT must not be negative");
    end

    logic [BSW-1:0] cpuBank, dmaBank;
    logic [RW-1:0]  cpuRow, dmaRow;

    assign cpuRow = spmAddress[AW-1:BW];
    assign dmaRow = dmaAddress[AW-1:BW];

    if (NUM_BANKS == 1) begin : gOneBank
        assign cpuBank = '0;
        assign dmaBank = '0;
    end else begin : gMultiBank
        assign cpuBank = spmAddress[BSW-1:0];
        assign dmaBank = dmaAddress[BSW-1:0];
    end

    logic [SW-1:0] starveCount;
    logic          conflict, dmaWins, dmaGrant, cpuAccept;

    // Arbitration: CPU owns a contested bank until the DMA has starved long enough.
    always_comb begin
        conflict  = reset && spmCs && dmaReq && (cpuBank == dmaBank);
        dmaWins   = conflict && (STARVE_LIMIT != 0) && (starveCount == LIMIT);
        dmaGrant  = reset && dmaReq && (!conflict || dmaWins);
        cpuAccept = reset && spmCs && !dmaWins;
    end

    assign dmaAck   = dmaGrant;
    assign spmStall = dmaWins;

    // Starvation counter: counts consecutive lost conflicts, cleared whenever the DMA is granted.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            starveCount <= '0;
        end else if (dmaGrant) begin
            starveCount <= '0;
        end else if (conflict && starveCount != '1) begin
            starveCount <= starveCount + 1'b1;
        end
    end

    logic [31:0] bankRdata [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : gBank
        logic          cpuHit, dmaHit, we, re;
        logic [RW-1:0] row;
        logic [3:0]    be;
        logic [31:0]   wdata;
        logic [7:0]    ram [4][ROWS];
        logic [31:0]   rdata;

        // Bank port mux: arbitration guarantees at most one port hits this bank per cycle.
        always_comb begin
            // NOTE: every output gets a default first so no path through the block infers a latch.
            row    = '0;
            we     = 1'b0;
            re     = 1'b0;
            be     = '0;
            wdata  = '0;
            cpuHit = cpuAccept && (cpuBank == BSW'(b));
            dmaHit = dmaGrant && (dmaBank == BSW'(b));
            if (cpuHit) begin
                row   = cpuRow;
                we    = spmWe;
                re    = !spmWe;
                be    = spmByteEnables;
                wdata = dataToSpm;
            end else if (dmaHit) begin
                row   = dmaRow;
                we    = dmaWe;
                re    = !dmaWe;
                be    = dmaByteEnables;
                wdata = dmaDataIn;
            end
        end

        // Four byte lanes with synchronous write and synchronous read-before-write.
        always_ff @(posedge clock) begin
            // NOTE: the array has no reset; contents survive reset and writes are blocked via the grants.
            for (int l = 0; l < 4; l++) begin
                if (we && be[l]) begin
                    ram[l][row] <= wdata[8*l +: 8];
                end
            end
            if (re) begin
                rdata <= {ram[3][row], ram[2][row], ram[1][row], ram[0][row]};
            end
        end

        assign bankRdata[b] = rdata;
    end

    logic           cpuRdValid, dmaRdValid;
    logic [BSW-1:0] cpuRdBank, dmaRdBank;
    logic [31:0]    cpuHold, dmaHold;

    // Read-return tracking: remember which bank answers next cycle and hold the last result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpuRdValid <= 1'b0;
            dmaRdValid <= 1'b0;
            cpuRdBank  <= '0;
            dmaRdBank  <= '0;
            cpuHold    <= '0;
            dmaHold    <= '0;
        end else begin
            cpuRdValid <= cpuAccept && !spmWe;
            dmaRdValid <= dmaGrant && !dmaWe;
            if (cpuAccept && !spmWe) cpuRdBank <= cpuBank;
            if (dmaGrant && !dmaWe)  dmaRdBank <= dmaBank;
            if (cpuRdValid) cpuHold <= bankRdata[cpuRdBank];
            if (dmaRdValid) dmaHold <= bankRdata[dmaRdBank];
        end
    end

    assign dataFromSpm  = cpuRdValid ? bankRdata[cpuRdBank] : cpuHold;
    assign dmaDataOut   = dmaRdValid ? bankRdata[dmaRdBank] : dmaHold;
    assign dmaReadValid = dmaRdValid;

endmodule

// File: tb/tb_spm_banked.sv
// tb_spm_banked: randomized traffic on both ports against a word-level memory model,
// plus directed scenarios with literal expectations.
module tb_spm_banked;

    localparam int AW = 11;

    logic          clock = 1'b0;
    logic          reset = 1'b0;

    logic          spmCs, spmWe, spmStall;
    logic [AW-1:0] spmAddress;
    logic [3:0]    spmByteEnables;
    logic [31:0]   dataToSpm, dataFromSpm;
    logic          dmaReq, dmaWe, dmaAck, dmaReadValid;
    logic [AW-1:0] dmaAddress;
    logic [3:0]    dmaByteEnables;
    logic [31:0]   dmaDataIn, dmaDataOut;

    logic          nsCs, nsWe, nsStall;
    logic [AW-1:0] nsAddress;
    logic [31:0]   nsDataTo, nsDataFrom;
    logic          nsDmaReq, nsAck, nsDmaReadValid;
    logic [AW-1:0] nsDmaAddress;
    logic [31:0]   nsDmaDataOut;

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    spm_banked #(.SIZE_IN_BYTES(8192), .NUM_BANKS(4), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .spmCs(spmCs), .spmWe(spmWe), .spmAddress(spmAddress), .spmByteEnables(spmByteEnables),
        .dataToSpm(dataToSpm), .dataFromSpm(dataFromSpm), .spmStall(spmStall),
        .dmaReq(dmaReq), .dmaWe(dmaWe), .dmaAddress(dmaAddress), .dmaByteEnables(dmaByteEnables),
        .dmaDataIn(dmaDataIn), .dmaAck(dmaAck), .dmaDataOut(dmaDataOut), .dmaReadValid(dmaReadValid)
    );

    spm_banked #(.SIZE_IN_BYTES(8192), .NUM_BANKS(4), .STARVE_LIMIT(0)) nsDut (
        .clock(clock), .reset(reset),
        .spmCs(nsCs), .spmWe(nsWe), .spmAddress(nsAddress), .spmByteEnables(4'hF),
        .dataToSpm(nsDataTo), .dataFromSpm(nsDataFrom), .spmStall(nsStall),
        .dmaReq(nsDmaReq), .dmaWe(1'b0), .dmaAddress(nsDmaAddress), .dmaByteEnables(4'hF),
        .dmaDataIn(32'h0), .dmaAck(nsAck), .dmaDataOut(nsDmaDataOut), .dmaReadValid(nsDmaReadValid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    // Reference model: a flat word memory, word-level arbitration rules, one-cycle read return.
    logic [31:0] modelMem [2048];
    logic [31:0] expCpuData  = '0;
    logic [31:0] expDmaData  = '0;
    logic        expDmaValid = 1'b0;
    int          starve      = 0;
    logic        mConflict, mStall, mAck, mCpuAcc;

    always @(negedge clock) begin
        if (!reset) begin
            expCpuData  = '0;
            expDmaData  = '0;
            expDmaValid = 1'b0;
            starve      = 0;
        end
        check("cpu_rdata", dataFromSpm, expCpuData);
        check("dma_rdata", dmaDataOut, expDmaData);
        check("dma_rvalid", 32'(dmaReadValid), 32'(expDmaValid));
        if (!reset) begin
            check("ack_in_reset", 32'(dmaAck), 32'd0);
            check("stall_in_reset", 32'(spmStall), 32'd0);
        end else begin
            mConflict = spmCs && dmaReq && ((int'(spmAddress) % 4) == (int'(dmaAddress) % 4));
            mStall    = mConflict && (starve == 4);
            mAck      = dmaReq && (!mConflict || mStall);
            mCpuAcc   = spmCs && !mStall;
            check("dma_ack", 32'(dmaAck), 32'(mAck));
            check("spm_stall", 32'(spmStall), 32'(mStall));
            expDmaValid = mAck && !dmaWe;
            if (mAck && !dmaWe) expDmaData = modelMem[dmaAddress];
            if (mCpuAcc && !spmWe) expCpuData = modelMem[spmAddress];
            if (mCpuAcc && spmWe)
                modelMem[spmAddress] = merge(modelMem[spmAddress], dataToSpm, spmByteEnables);
            if (mAck && dmaWe)
                modelMem[dmaAddress] = merge(modelMem[dmaAddress], dmaDataIn, dmaByteEnables);
            if (mAck) starve = 0;
            else if (mConflict) starve++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cpuSet(input logic cs, input logic we, input int addr,
                          input logic [3:0] be, input logic [31:0] d);
        spmCs = cs; spmWe = we; spmAddress = AW'(addr); spmByteEnables = be; dataToSpm = d;
    endtask

    task automatic dmaSet(input logic req, input logic we, input int addr,
                          input logic [3:0] be, input logic [31:0] d);
        dmaReq = req; dmaWe = we; dmaAddress = AW'(addr); dmaByteEnables = be; dmaDataIn = d;
    endtask

    logic holdCpu, holdDma;
    int   dBank;

    initial begin
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        dmaSet(0, 0, 0, 4'h0, 32'h0);
        nsCs = 0; nsWe = 0; nsAddress = '0; nsDataTo = '0; nsDmaReq = 0; nsDmaAddress = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Known contents for the working set of words 0..31.
        for (int i = 0; i < 32; i++) begin
            cpuSet(1, 1, i, 4'hF, 32'hC0DE0000 | 32'(i));
            step();
        end
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        step();

        // Full-word write then read, result held through idle cycles.
        cpuSet(1, 1, 5, 4'hF, 32'hDEADBEEF); step();
        cpuSet(1, 0, 5, 4'hF, 32'h0);        step();
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); check("word5_readback", dataFromSpm, 32'hDEADBEEF);
            step();
        end

        // Single byte-lane write.
        cpuSet(1, 1, 6, 4'hF, 32'h11223344);    step();
        cpuSet(1, 1, 6, 4'b0100, 32'h00AA0000); step();
        cpuSet(1, 0, 6, 4'hF, 32'h0);           step();
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        @(negedge clock); check("byte_lane2", dataFromSpm, 32'h11AA3344);
        step();

        // Different banks in the same cycle.
        cpuSet(1, 0, 4, 4'hF, 32'h0);
        dmaSet(1, 0, 5, 4'hF, 32'h0);
        @(negedge clock);
        check("par_ack", 32'(dmaAck), 32'd1);
        check("par_stall", 32'(spmStall), 32'd0);
        step();
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        dmaSet(0, 0, 0, 4'h0, 32'h0);
        @(negedge clock);
        check("par_cpu_data", dataFromSpm, 32'hC0DE0004);
        check("par_dma_data", dmaDataOut, 32'hDEADBEEF);
        check("par_dma_valid", 32'(dmaReadValid), 32'd1);
        step();

        // Same-bank starvation: four lost conflicts, then the DMA wins once.
        cpuSet(1, 0, 0, 4'hF, 32'h0);
        dmaSet(1, 0, 8, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("starve_ack", 32'(dmaAck), 32'd0);
            check("starve_stall", 32'(spmStall), 32'd0);
            step();
        end
        @(negedge clock);
        check("starve_win_ack", 32'(dmaAck), 32'd1);
        check("starve_win_stall", 32'(spmStall), 32'd1);
        step();
        @(negedge clock);
        check("starve_dma_data", dmaDataOut, 32'hC0DE0008);
        check("starve_dma_valid", 32'(dmaReadValid), 32'd1);
        check("starve_cleared", 32'(dmaAck), 32'd0);
        check("starve_cpu_held", dataFromSpm, 32'hC0DE0000);
        step();
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        dmaSet(0, 0, 0, 4'h0, 32'h0);
        step();

        // Random traffic; a stalled CPU and an un-acked DMA both hold their request.
        holdCpu = 0;
        holdDma = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!holdDma)
                dmaSet(($urandom_range(0, 4) < 3), 1'($urandom), $urandom_range(0, 31),
                       4'($urandom), $urandom);
            if (!holdCpu) begin
                dBank = int'(dmaAddress) % 4;
                if ($urandom_range(0, 1) == 1)
                    cpuSet(($urandom_range(0, 3) != 0), 1'($urandom),
                           $urandom_range(0, 7) * 4 + dBank, 4'($urandom), $urandom);
                else
                    cpuSet(($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 31),
                           4'($urandom), $urandom);
            end
            @(negedge clock);
            holdCpu = spmStall;
            holdDma = dmaReq && !dmaAck;
            step();
        end
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        dmaSet(0, 0, 0, 4'h0, 32'h0);
        step();

        // Reset right after an accepted DMA read; memory survives, writes are blocked.
        cpuSet(1, 1, 9, 4'hF, 32'h600DF00D); step();
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        dmaSet(1, 0, 9, 4'hF, 32'h0);
        @(negedge clock); check("pre_reset_ack", 32'(dmaAck), 32'd1);
        step();
        reset = 1'b0;
        dmaSet(0, 0, 0, 4'h0, 32'h0);
        cpuSet(1, 1, 9, 4'hF, 32'hBAD0BAD0);
        @(negedge clock);
        check("rst_rvalid", 32'(dmaReadValid), 32'd0);
        check("rst_cpu_data", dataFromSpm, 32'd0);
        check("rst_dma_data", dmaDataOut, 32'd0);
        check("rst_ack", 32'(dmaAck), 32'd0);
        check("rst_stall", 32'(spmStall), 32'd0);
        step();
        step();
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        reset = 1'b1;
        step();
        cpuSet(1, 0, 9, 4'hF, 32'h0); step();
        cpuSet(0, 0, 0, 4'h0, 32'h0);
        @(negedge clock); check("post_reset_mem", dataFromSpm, 32'h600DF00D);
        step();

        // Starvation protection disabled: DMA waits until the CPU lets go.
        nsCs = 1; nsWe = 1; nsAddress = AW'(0); nsDataTo = 32'h0A0A0A0A; step();
        nsAddress = AW'(8); nsDataTo = 32'h08080808;                     step();
        nsWe = 0; nsAddress = AW'(0);
        nsDmaReq = 1; nsDmaAddress = AW'(8);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("ns_ack", 32'(nsAck), 32'd0);
            check("ns_stall", 32'(nsStall), 32'd0);
            if (k > 0) check("ns_cpu_data", nsDataFrom, 32'h0A0A0A0A);
            step();
        end
        nsCs = 0;
        @(negedge clock); check("ns_release_ack", 32'(nsAck), 32'd1);
        step();
        nsDmaReq = 0;
        @(negedge clock);
        check("ns_rvalid", 32'(nsDmaReadValid), 32'd1);
        check("ns_dma_data", nsDmaDataOut, 32'h08080808);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
